// File: rtl/msg_schedule.sv
// SHA-256 message-schedule stage: passes block words through for rounds 0-15
// and expands them from a 16-word sliding window for rounds 16-63.
module msg_schedule #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ROUNDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic [5:0]        k_num,
  input  logic [WORD_W-1:0] in_word,
  output logic [WORD_W-1:0] w_out,
  output logic              w_valid,
  output logic              blk_done,
  output logic              seq_err
);

  localparam int unsigned IDX_W = 6;
  localparam int unsigned WIN_N = 16;
  localparam logic [IDX_W-1:0] LAST_T = IDX_W'(ROUNDS - 1);
  localparam logic [IDX_W-1:0] WIN_T  = IDX_W'(WIN_N);

  // win[WIN_N-1] is W[t-1], win[0] is W[t-16]
  logic [WORD_W-1:0] win [WIN_N];
  logic [IDX_W-1:0]  exp_idx;
  logic [WORD_W-1:0] new_word_c;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Next schedule word: block word for early rounds, expansion afterwards
  always_comb begin
    new_word_c = in_word;
    if (k_num >= WIN_T) begin
      new_word_c = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
    end
  end

  // Window shift, output register and round-index tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      w_out    <= '0;
      w_valid  <= 1'b0;
      blk_done <= 1'b0;
      seq_err  <= 1'b0;
      exp_idx  <= '0;
      for (int i = 0; i < int'(WIN_N); i++) begin
        win[i] <= '0;
      end
    end else begin
      w_valid  <= 1'b0;
      blk_done <= 1'b0;
      if (step) begin
        for (int i = 0; i < int'(WIN_N) - 1; i++) begin
          win[i] <= win[i+1];
        end
        win[WIN_N-1] <= new_word_c;
        w_out        <= new_word_c;
        w_valid      <= 1'b1;
        blk_done     <= (k_num == LAST_T);
        if (k_num != exp_idx) begin
          seq_err <= 1'b1;
        end
        // Resynchronise to the received index so a single slip flags once
        exp_idx <= (k_num == LAST_T) ? '0 : k_num + IDX_W'(1);
      end
    end
  end

endmodule
